bnn_layer_sequencer: RTL

// - Parametrised layer sequencer for the BNN accelerator; drives the read -> XNOR/popcount -> accumulate -> threshold -> pool -> write datapath.
// - Runs N_LAYERS layers from a per-layer descriptor table, ping-ponging activations between two banks of the activation RAM.
// - Generates read, weight, threshold and write addresses, accumulator framing and write strobes.
// - Replaces hard-wired per-layer FSMs with stall support, pipeline drain and partial-pool flush.

---
 rtl/bnn_layer_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bnn_layer_sequencer.sv
// Layer sequencer for the BNN accelerator: walks the per-layer descriptor table and
// issues read/weight/threshold addresses, accumulator framing and pooled write strobes.
//
// state | meaning
// IDLE  | waiting for iSTART
// LOAD  | latch descriptor for current layer, clear per-layer counters
// RUN   | one read per non-stalled cycle
// DRAIN | wait for pending writes to leave the delay line
// DONE  | one-cycle completion pulse
module bnn_layer_sequencer #(
   parameter int N_LAYERS    = 5,
   parameter int AW          = 9,
   parameter int CW          = 10,
   parameter int WAW         = 12,
   parameter int TAW         = 8,
   parameter int BANK_OFFSET = 252,
   parameter int PIPE_LAT    = 3,
   localparam int LW         = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic           iCLK,
   input  logic           iRSTn,
   input  logic           iCLR,
   input  logic           iSTART,
   input  logic           iSTALL,
   output logic [LW-1:0]  oDESC_IDX,
   input  logic [CW-1:0]  iDESC_NACC,
   input  logic [CW-1:0]  iDESC_NOUT,
   input  logic [AW-1:0]  iDESC_STRIDE,
   input  logic [2:0]     iDESC_POOL,
   output logic           oRD_EN,
   output logic [AW-1:0]  oRD_ADDR,
   output logic [WAW-1:0] oW_ADDR,
   output logic [TAW-1:0] oTH_ADDR,
   output logic           oACC_CLR,
   output logic           oACC_LAST,
   output logic           oWR_EN,
   output logic [AW-1:0]  oWR_ADDR,
   output logic [LW-1:0]  oLAYER,
   output logic           oBUSY,
   output logic           oDONE
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [LW-1:0]       layer_q;
   logic [CW-1:0]       nacc_m1_q, nout_m1_q, k_q, g_q;
   logic [AW-1:0]       stride_q, gbase_q, wcnt_q;
   logic [2:0]          pool_m1_q, pcnt_q;
   logic [WAW-1:0]      w_addr_q;
   logic [TAW-1:0]      th_addr_q;
   logic [PIPE_LAT-1:0] pipe_q;

   logic          issue, k_last, g_last, pool_full, wr_flag, wr_fire, last_layer;
   logic [AW-1:0] rd_base, wr_base;

   assign issue      = (state_q == S_RUN) && !iSTALL && !iCLR;
   assign k_last     = (k_q == nacc_m1_q);
   assign g_last     = (g_q == nout_m1_q);
   assign pool_full  = (pcnt_q == pool_m1_q);
   // last neuron of the layer also writes, flushing a partially filled pool group
   assign wr_flag    = issue && k_last && (pool_full || g_last);
   assign wr_fire    = pipe_q[PIPE_LAT-1] && !iCLR;
   assign last_layer = (layer_q == LW'(N_LAYERS - 1));
   assign rd_base    = layer_q[0] ? AW'(BANK_OFFSET) : '0;
   assign wr_base    = layer_q[0] ? '0 : AW'(BANK_OFFSET);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (iSTART) state_d = S_LOAD;
         S_LOAD:  state_d = S_RUN;
         S_RUN:   if (issue && k_last && g_last) state_d = S_DRAIN;
         S_DRAIN: if (pipe_q == '0) state_d = last_layer ? S_DONE : S_LOAD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (iCLR) state_d = S_IDLE;
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q   <= S_IDLE;
         layer_q   <= '0;
         nacc_m1_q <= '0;
         nout_m1_q <= '0;
         stride_q  <= '0;
         pool_m1_q <= '0;
         k_q       <= '0;
         g_q       <= '0;
         gbase_q   <= '0;
         wcnt_q    <= '0;
         pcnt_q    <= '0;
         w_addr_q  <= '0;
         th_addr_q <= '0;
         pipe_q    <= '0;
      end else begin
         state_q <= state_d;
         pipe_q  <= iCLR ? '0 : ((pipe_q << 1) | PIPE_LAT'(wr_flag));
         if (wr_fire) wcnt_q <= wcnt_q + 1'b1;
         if (iCLR) begin
            layer_q <= '0;
         end else begin
            case (state_q)
               S_IDLE: if (iSTART) begin
                  layer_q   <= '0;
                  w_addr_q  <= '0;
                  th_addr_q <= '0;
               end
               S_LOAD: begin
                  nacc_m1_q <= (iDESC_NACC == '0) ? '0 : iDESC_NACC - 1'b1;
                  nout_m1_q <= (iDESC_NOUT == '0) ? '0 : iDESC_NOUT - 1'b1;
                  pool_m1_q <= (iDESC_POOL == '0) ? '0 : iDESC_POOL - 3'd1;
                  stride_q  <= iDESC_STRIDE;
                  k_q       <= '0;
                  g_q       <= '0;
                  gbase_q   <= '0;
                  wcnt_q    <= '0;
                  pcnt_q    <= '0;
               end
               S_RUN: if (issue) begin
                  w_addr_q <= w_addr_q + 1'b1;
                  if (k_last) begin
                     k_q       <= '0;
                     g_q       <= g_q + 1'b1;
                     gbase_q   <= gbase_q + stride_q;
                     th_addr_q <= th_addr_q + 1'b1;
                     pcnt_q    <= pool_full ? 3'd0 : pcnt_q + 3'd1;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
               S_DRAIN: if ((pipe_q == '0) && !last_layer) layer_q <= layer_q + 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign oDESC_IDX = layer_q;
   assign oLAYER    = layer_q;
   assign oRD_EN    = issue;
   assign oRD_ADDR  = issue ? (rd_base + gbase_q + AW'(k_q)) : '0;
   assign oW_ADDR   = w_addr_q;
   assign oTH_ADDR  = th_addr_q;
   assign oACC_CLR  = issue && (k_q == '0);
   assign oACC_LAST = issue && k_last;
   assign oWR_EN    = wr_fire;
   assign oWR_ADDR  = wr_fire ? (wr_base + wcnt_q) : '0;
   assign oBUSY     = (state_q != S_IDLE);
   assign oDONE     = (state_q == S_DONE) && !iCLR;

endmodule
